// File: rtl/mismatch_scoreboard.sv
// mismatch_scoreboard
//   Result collector for circuit testbenches. It watches the per-output
//   valid/err flag pairs coming from the error monitors. It counts sample
//   cycles and per-channel mismatches, and records the first failing sample.
//   When the run ends it raises a registered done/pass verdict.
//
// Build option:
//   SCOREBOARD_STOP_ON_FAIL_EN - when defined, the first sample that carries
//   any channel error ends the run. That sample is still counted.
//
// Ports:
//   Clk             in   single clock, rising edge
//   Rst             in   asynchronous active-high reset
//   clear           in   synchronous restart to IDLE, zeroes all outputs
//   valid[NUM_CH]   in   per-channel comparison valid
//   err[NUM_CH]     in   per-channel mismatch (ignored unless valid)
//   sample_cnt      out  sample cycles counted this run
//   err_cnt         out  per-channel error counts, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   first_err_cycle out  sample index of the first error
//   first_err_mask  out  channels failing in that first error sample
//   done            out  run complete
//   pass            out  run complete with zero errors
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | waiting for the first sample (any valid bit set)
// RUN   | counting samples until NUM_SAMPLES is reached
// DONE  | verdict latched; inputs ignored, outputs hold

module mismatch_scoreboard #(
  parameter int NUM_CH      = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int NUM_SAMPLES = 1000
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        clear,
  input  logic [NUM_CH-1:0]           valid,
  input  logic [NUM_CH-1:0]           err,
  output logic [CNT_WIDTH-1:0]        sample_cnt,
  output logic [NUM_CH*CNT_WIDTH-1:0] err_cnt,
  output logic [CNT_WIDTH-1:0]        first_err_cycle,
  output logic [NUM_CH-1:0]           first_err_mask,
  output logic                        done,
  output logic                        pass
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Sample index that completes the run. Comparing against the
  // pre-increment count lets the final sample end the run on its own edge.
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_SAMPLES - 1);

  logic [1:0]        state;
  logic              err_seen;
  logic              sample;
  logic [NUM_CH-1:0] hit;
  logic              any_hit;
  logic              last;
  logic              finish;

  assign sample  = (state != ST_DONE) && (|valid);
  assign hit     = valid & err;
  assign any_hit = |hit;
  assign last    = (sample_cnt == LAST_IDX);

`ifdef SCOREBOARD_STOP_ON_FAIL_EN
  assign finish = last || any_hit;
`else
  assign finish = last;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state           <= ST_IDLE;
      err_seen        <= 1'b0;
      sample_cnt      <= '0;
      err_cnt         <= '0;
      first_err_cycle <= '0;
      first_err_mask  <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else if (clear) begin
      state           <= ST_IDLE;
      err_seen        <= 1'b0;
      sample_cnt      <= '0;
      err_cnt         <= '0;
      first_err_cycle <= '0;
      first_err_mask  <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else if (sample) begin
      sample_cnt <= sample_cnt + CNT_WIDTH'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        err_cnt[i*CNT_WIDTH +: CNT_WIDTH] <=
          err_cnt[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(hit[i]);
      end
      // err_seen gates the capture so only the first failing sample is kept.
      if (any_hit && !err_seen) begin
        err_seen        <= 1'b1;
        first_err_cycle <= sample_cnt;
        first_err_mask  <= hit;
      end
      if (finish) begin
        state <= ST_DONE;
        done  <= 1'b1;
        // Include this sample's errors, which are not yet in err_seen.
        pass  <= !(err_seen || any_hit);
      end else begin
        state <= ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_mismatch_scoreboard.sv
// tb_mismatch_scoreboard
//   Directed testbench for mismatch_scoreboard using default parameters
//   (2 channels, 16-bit counters, 1000 samples per run). Expected values are
//   hand-computed constants. Compile with SCOREBOARD_STOP_ON_FAIL_EN defined
//   to exercise the early-stop build.

module tb_mismatch_scoreboard;

  logic        Clk;
  logic        Rst;
  logic        clear;
  logic [1:0]  valid;
  logic [1:0]  err;
  logic [15:0] sample_cnt;
  logic [31:0] err_cnt;
  logic [15:0] first_err_cycle;
  logic [1:0]  first_err_mask;
  logic        done;
  logic        pass;

  int n_checks = 0;
  int n_errors = 0;

  mismatch_scoreboard #(
    .NUM_CH(2), .CNT_WIDTH(16), .NUM_SAMPLES(1000)
  ) dut (
    .Clk(Clk), .Rst(Rst), .clear(clear), .valid(valid), .err(err),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .first_err_cycle(first_err_cycle), .first_err_mask(first_err_mask),
    .done(done), .pass(pass)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] e);
    valid = v;
    err   = e;
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    valid = 2'b00;
    err   = 2'b00;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    Rst   = 1'b1;
    clear = 1'b0;
    valid = 2'b00;
    err   = 2'b00;
    #1;
    check("rst_sample_cnt", 32'(sample_cnt), 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_first_cycle", 32'(first_err_cycle), 0);
    check("rst_first_mask", 32'(first_err_mask), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    #20 Rst = 1'b0;

    // Masked errors: no valid bits, so nothing is counted and the run does not start.
    for (int i = 0; i < 10; i++) drive(2'b00, 2'b11);
    check("mask_sample_cnt", 32'(sample_cnt), 0);
    check("mask_err_cnt", err_cnt, 0);
    check("mask_done", 32'(done), 0);

    // Clean run of 1000 samples.
    for (int i = 0; i < 999; i++) drive(2'b11, 2'b00);
    check("clean_cnt_999", 32'(sample_cnt), 999);
    check("clean_done_early", 32'(done), 0);
    drive(2'b11, 2'b00);
    check("clean_done", 32'(done), 1);
    check("clean_pass", 32'(pass), 1);
    check("clean_sample_cnt", 32'(sample_cnt), 1000);
    check("clean_err_cnt", err_cnt, 0);

    // DONE is terminal: further inputs are ignored.
    for (int i = 0; i < 5; i++) drive(2'b11, 2'b11);
    check("hold_sample_cnt", 32'(sample_cnt), 1000);
    check("hold_err_cnt", err_cnt, 0);
    check("hold_pass", 32'(pass), 1);

    // clear in DONE.
    do_clear();
    check("clr_done", 32'(done), 0);
    check("clr_pass", 32'(pass), 0);
    check("clr_sample_cnt", 32'(sample_cnt), 0);

    // clear coincident with a sample discards that sample.
    drive(2'b11, 2'b00);
    drive(2'b11, 2'b00);
    check("pre_clr_cnt", 32'(sample_cnt), 2);
    clear = 1'b1;
    drive(2'b11, 2'b11);
    clear = 1'b0;
    check("clr_sample_discard", 32'(sample_cnt), 0);
    check("clr_err_discard", err_cnt, 0);
    drive(2'b11, 2'b00);
    check("post_clr_cnt", 32'(sample_cnt), 1);
    do_clear();

`ifdef SCOREBOARD_STOP_ON_FAIL_EN
    // Stop on fail: err[1] at sample 42 ends the run.
    for (int s = 0; s < 43; s++) drive(2'b11, (s == 42) ? 2'b10 : 2'b00);
    check("sof_done", 32'(done), 1);
    check("sof_pass", 32'(pass), 0);
    check("sof_sample_cnt", 32'(sample_cnt), 43);
    check("sof_first_cycle", 32'(first_err_cycle), 42);
    check("sof_first_mask", 32'(first_err_mask), 32'h2);
    check("sof_err_cnt", err_cnt, 32'h0001_0000);
    for (int i = 0; i < 5; i++) drive(2'b11, 2'b11);
    check("sof_hold_cnt", 32'(sample_cnt), 43);
    check("sof_hold_err", err_cnt, 32'h0001_0000);
    do_clear();
`else
    // Error capture: err[0] at samples 5 and 7, err[1] at sample 7.
    for (int s = 0; s < 1000; s++)
      drive(2'b11, (s == 5) ? 2'b01 : (s == 7) ? 2'b11 : 2'b00);
    check("ecap_done", 32'(done), 1);
    check("ecap_pass", 32'(pass), 0);
    check("ecap_ch0", 32'(err_cnt[15:0]), 2);
    check("ecap_ch1", 32'(err_cnt[31:16]), 1);
    check("ecap_first_cycle", 32'(first_err_cycle), 5);
    check("ecap_first_mask", 32'(first_err_mask), 32'h1);
    do_clear();

    // Error only in the final sample still fails the verdict.
    for (int s = 0; s < 1000; s++) drive(2'b11, (s == 999) ? 2'b10 : 2'b00);
    check("last_err_done", 32'(done), 1);
    check("last_err_pass", 32'(pass), 0);
    check("last_err_cycle", 32'(first_err_cycle), 999);
    do_clear();

    // Partial valid: only channel 1 is compared.
    for (int i = 0; i < 3; i++) drive(2'b10, 2'b11);
    check("pv_sample_cnt", 32'(sample_cnt), 3);
    check("pv_ch0", 32'(err_cnt[15:0]), 0);
    check("pv_ch1", 32'(err_cnt[31:16]), 3);
    check("pv_first_mask", 32'(first_err_mask), 32'h2);
    do_clear();
`endif

    // Asynchronous reset between edges at sample 300.
    for (int i = 0; i < 300; i++) drive(2'b11, 2'b00);
    check("pre_rst_cnt", 32'(sample_cnt), 300);
    #2 Rst = 1'b1;
    #1;
    check("arst_sample_cnt", 32'(sample_cnt), 0);
    check("arst_done", 32'(done), 0);
    #1 Rst = 1'b0;
    valid = 2'b00;
    err   = 2'b00;
    for (int i = 0; i < 1000; i++) drive(2'b11, 2'b00);
    check("fresh_done", 32'(done), 1);
    check("fresh_pass", 32'(pass), 1);
    check("fresh_sample_cnt", 32'(sample_cnt), 1000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mismatch_scoreboard.md
# mismatch_scoreboard

- Downstream result collector for the circuit testbenches.
- Consumes the per-output `valid`/`err` flags that the error monitors produce, one pair per compared output (for example `xvalid`/`xerr` and `zvalid`/`zerr`).
- Counts compared samples and per-channel mismatches, and records the first failure.
- Runs a small FSM that ends each run with a registered `done`/`pass` verdict, so the bench can end the simulation on one signal.

## Interface
Parameters:
- `NUM_CH`, 2: number of monitored channels.
- `CNT_WIDTH`, 16: width of the sample counter and of each error counter.
- `NUM_SAMPLES`, 1000: compare cycles per run. Must satisfy 1 ≤ `NUM_SAMPLES` < 2^`CNT_WIDTH`.

Ports:
- `Clk`  in  1  single clock; all state changes on the rising edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous restart to IDLE.
- `valid`  in  `NUM_CH`  per-channel "comparison valid this cycle".
- `err`  in  `NUM_CH`  per-channel mismatch flag; meaningful only when the matching `valid` bit is 1.
- `sample_cnt`  out  `CNT_WIDTH`  number of sample cycles counted.
- `err_cnt`  out  `NUM_CH*CNT_WIDTH`  per-channel error counts; channel i occupies bits [i*`CNT_WIDTH` +: `CNT_WIDTH`].
- `first_err_cycle`  out  `CNT_WIDTH`  sample index of the first error.
- `first_err_mask`  out  `NUM_CH`  channels that failed in that first error sample.
- `done`  out  1  run complete.
- `pass`  out  1  run complete with zero errors.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- A sample is any cycle in IDLE or RUN with |`valid` = 1.
- A channel error is `valid[i] & err[i]`. If `err[i]` is high while `valid[i]` is low, the error is ignored.
- Transitions:
  - IDLE→RUN on the first sample. That cycle is counted as sample index 0.
  - RUN→DONE on the cycle in which the sample being counted makes the total equal `NUM_SAMPLES`. With `NUM_SAMPLES`=1 the run goes IDLE→DONE directly.
  - DONE is terminal. In DONE, `valid` and `err` are ignored and all outputs hold.
- On each sample:
  - `sample_cnt` increments by 1.
  - `err_cnt[i]` increments by 1 for each channel with an error.
  - Counters cannot overflow, because `NUM_SAMPLES` < 2^`CNT_WIDTH`.
- First error:
  - On the first sample containing any channel error, `first_err_cycle` captures the pre-increment `sample_cnt`.
  - `first_err_mask` captures `valid & err` from the same cycle.
  - Both are written once per run; later errors do not change them.
- Verdict: on entering DONE, `done`=1 and `pass`=1 only if every `err_cnt` is 0, including any error in the final sample.
- `clear`:
  - Returns the FSM to IDLE and zeroes every output register.
  - Takes priority over sampling in the same cycle; that cycle's sample is discarded.
  - Acts in any state.
- `Rst` asserted at any time, including mid-run: all outputs are 0 and the state is IDLE immediately, without waiting for a clock edge.

## Timing
- Reset values: `sample_cnt`, `err_cnt`, `first_err_cycle`, `first_err_mask`, `done` and `pass` are all 0.
- All outputs are registered. A sample at edge k is visible on the outputs after edge k; latency is 1 cycle.
- `done` and `pass` rise in the cycle after the final sample and stay high until `clear` or `Rst`.
- No handshake back-pressure: every valid cycle is accepted.

## Configuration
- `SCOREBOARD_STOP_ON_FAIL_EN` defined:
  - The first sample containing a channel error moves IDLE/RUN→DONE. That sample's counts are included.
  - Result: `done`=1, `pass`=0, and `sample_cnt` ≤ `NUM_SAMPLES`.
- `SCOREBOARD_STOP_ON_FAIL_EN` undefined:
  - Errors never end the run early.
  - The run always completes `NUM_SAMPLES` samples.

## Test plan
- Clean run, defaults: `valid`=2'b11 and `err`=0 for 1000 cycles → `done`=1 and `pass`=1 one cycle after the 1000th sample; `sample_cnt`=1000; all `err_cnt`=0.
- Error capture:
  - Stimulus: `err[0]` high at samples 5 and 7, `err[1]` high at sample 7, both valid.
  - Response: `err_cnt` channel 0 = 2, channel 1 = 1; `first_err_cycle`=5; `first_err_mask`=2'b01; `pass`=0 at `done`.
- Masked error: `err`=2'b11 with `valid`=2'b00 for 10 cycles, then clean samples → no counting and state stays IDLE during those 10 cycles; final `pass`=1.
- Partial valid: `valid`=2'b10, `err`=2'b11 → only `err_cnt` channel 1 increments; `sample_cnt` increments by 1 per cycle.
- Reset and clear:
  - `Rst` pulsed between clock edges at sample 300 → all outputs 0 before the next edge; a fresh run then completes.
  - `clear` in DONE → IDLE with outputs 0 on the next cycle.
  - `clear` coincident with a sample → that sample is not counted.
- Stop-on-fail (`SCOREBOARD_STOP_ON_FAIL_EN` defined, `NUM_SAMPLES`=1000): `err[1]` at sample 42 → `done`=1, `pass`=0, `sample_cnt`=43 and `first_err_cycle`=42 after the next edge; later inputs are ignored.
